// File: rtl/exp_beh_fa_pkg.sv
// Shared constants for the registered ripple full adder.
// Defaults give the classic single-bit, one-cycle registered adder.
package exp_beh_fa_pkg;

  localparam int DEFAULT_WIDTH   = 1;
  localparam bit DEFAULT_REG_OUT = 1'b1;

endpackage

// File: rtl/exp_beh_fa_if.sv
// Operand/result bundle between a driver and the adder; no backpressure.
// master drives operands and valid, slave (the adder) returns sum/carry/valid.
interface exp_beh_fa_if
  import exp_beh_fa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             out_valid;

  modport master (
    output A, B, Cin, in_valid,
    input  sum, carry, out_valid
  );

  modport slave (
    input  A, B, Cin, in_valid,
    output sum, carry, out_valid
  );

endinterface

// File: rtl/exp_beh_fa_full_adder_cell.sv
// One-bit full adder cell; purely combinational, zero latency.
// Chained through cin/cout to form the ripple carry path.
module exp_beh_fa_full_adder_cell
  import exp_beh_fa_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/exp_beh_fa.sv
// Ripple-carry adder {carry,sum} = A + B + Cin, optional output register (1 cycle).
// No backpressure: one result per cycle; out_valid is always in_valid delayed one cycle.
module exp_beh_fa
  import exp_beh_fa_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter bit REG_OUT = DEFAULT_REG_OUT
)(
  input  logic         clk,
  input  logic         rst_n,
  exp_beh_fa_if.slave  io
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_d;
  logic             carry_d;
  logic             out_valid_q;

  assign c[0] = io.Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    exp_beh_fa_full_adder_cell u_cell (
      .a    (io.A[i]),
      .b    (io.B[i]),
      .cin  (c[i]),
      .s    (sum_d[i]),
      .cout (c[i+1])
    );
  end

  assign carry_d = c[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= io.in_valid;
    end
  end

  assign io.out_valid = out_valid_q;

  if (REG_OUT) begin : g_reg
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;

    // Result holds across idle cycles so a downstream stage may sample late.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sum_q   <= '0;
        carry_q <= 1'b0;
      end else if (io.in_valid) begin
        sum_q   <= sum_d;
        carry_q <= carry_d;
      end
    end

    assign io.sum   = sum_q;
    assign io.carry = carry_q;
  end else begin : g_comb
    assign io.sum   = sum_d;
    assign io.carry = carry_d;
  end

endmodule

// File: tb/tb_exp_beh_fa.sv
// Bench for exp_beh_fa: three instances (1-bit reg, 8-bit reg, 1-bit comb)
// checked against an arithmetic reference model of A + B + Cin.
module tb_exp_beh_fa;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  exp_beh_fa_if #(.WIDTH(1)) if1 ();
  exp_beh_fa_if #(.WIDTH(8)) if8 ();
  exp_beh_fa_if #(.WIDTH(1)) if0 ();

  exp_beh_fa #(.WIDTH(1), .REG_OUT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .io(if1.slave));
  exp_beh_fa #(.WIDTH(8), .REG_OUT(1'b1)) dut8 (.clk(clk), .rst_n(rst_n), .io(if8.slave));
  exp_beh_fa #(.WIDTH(1), .REG_OUT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .io(if0.slave));

  int checks   = 0;
  int failures = 0;

  // Reference model: last accepted {carry,sum} and the valid seen one edge ago.
  logic [1:0] m1;
  logic       m1v;
  logic [8:0] m8;
  logic       m8v;

  task automatic drive(input logic a1, input logic b1, input logic c1, input logic v1,
                       input logic [7:0] a8, input logic [7:0] b8, input logic c8,
                       input logic v8);
    if1.A = a1; if1.B = b1; if1.Cin = c1; if1.in_valid = v1;
    if0.A = a1; if0.B = b1; if0.Cin = c1; if0.in_valid = v1;
    if8.A = a8; if8.B = b8; if8.Cin = c8; if8.in_valid = v8;
  endtask

  // Apply one cycle of stimulus; return at the following falling edge.
  task automatic step(input logic a1, input logic b1, input logic c1, input logic v1,
                      input logic [7:0] a8, input logic [7:0] b8, input logic c8,
                      input logic v8);
    drive(a1, b1, c1, v1, a8, b8, c8, v8);
    @(posedge clk);
    if (rst_n) begin
      if (v1) m1 = 2'(a1) + 2'(b1) + 2'(c1);
      if (v8) m8 = 9'(a8) + 9'(b8) + 9'(c8);
      m1v = v1;
      m8v = v8;
    end
    @(negedge clk);
  endtask

  task automatic model_clear();
    m1 = '0; m1v = 1'b0; m8 = '0; m8v = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({if1.carry, if1.sum, if1.out_valid} !== 3'b000) begin
      failures++;
      $display("FAIL reset_async_w1 got carry,sum,vld=%b required 000",
               {if1.carry, if1.sum, if1.out_valid});
    end
    checks++;
    if ({if8.carry, if8.sum, if8.out_valid} !== 10'b0) begin
      failures++;
      $display("FAIL reset_async_w8 got carry=%b sum=%h vld=%b required 0 00 0",
               if8.carry, if8.sum, if8.out_valid);
    end
    checks++;
    if (if0.out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_async_comb_vld got %b required 0", if0.out_valid);
    end
    // Edges with valid input while reset is held must not capture.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1, 1'b1);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({if1.carry, if1.sum, if1.out_valid, if8.carry, if8.sum, if8.out_valid} !== 13'b0) begin
      failures++;
      $display("FAIL reset_held got w1=%b%b%b w8=%b %h %b required zeros",
               if1.carry, if1.sum, if1.out_valid, if8.carry, if8.sum, if8.out_valid);
    end
    model_clear();
    rst_n = 1'b1;
  endtask

  task automatic test_exhaustive_w1();
    logic [1:0] tab [8];
    logic [2:0] v;
    tab = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      step(v[2], v[1], v[0], 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
      checks++;
      if ({if1.carry, if1.sum, if1.out_valid} !== {tab[i], 1'b1}) begin
        failures++;
        $display("FAIL exhaustive_w1 abc=%b got carry,sum,vld=%b required %b",
                 v, {if1.carry, if1.sum, if1.out_valid}, {tab[i], 1'b1});
      end
    end
  endtask

  task automatic test_hold();
    step(1'b1, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    checks++;
    if ({if1.carry, if1.sum, if1.out_valid} !== 3'b100) begin
      failures++;
      $display("FAIL hold_w1 got carry,sum,vld=%b required 100",
               {if1.carry, if1.sum, if1.out_valid});
    end
  endtask

  task automatic test_w8_directed();
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b1, 1'b1);
    checks++;
    if ({if8.carry, if8.sum, if8.out_valid} !== {1'b1, 8'h00, 1'b1}) begin
      failures++;
      $display("FAIL w8_full_ripple got carry=%b sum=%h vld=%b required 1 00 1",
               if8.carry, if8.sum, if8.out_valid);
    end
    step(1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h33, 1'b0, 1'b1);
    checks++;
    if ({if8.carry, if8.sum, if8.out_valid} !== {1'b0, 8'h8D, 1'b1}) begin
      failures++;
      $display("FAIL w8_5a_33 got carry=%b sum=%h vld=%b required 0 8d 1",
               if8.carry, if8.sum, if8.out_valid);
    end
  endtask

  task automatic test_random();
    logic [7:0] a8, b8;
    logic       a1, b1, c1, v1, c8, v8;
    for (int i = 0; i < 60; i++) begin
      a1 = 1'($urandom); b1 = 1'($urandom); c1 = 1'($urandom);
      v1 = ($urandom_range(3) != 0);
      a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
      v8 = ($urandom_range(3) != 0);
      step(a1, b1, c1, v1, a8, b8, c8, v8);
      checks++;
      if ({if1.carry, if1.sum, if1.out_valid} !== {m1, m1v}) begin
        failures++;
        $display("FAIL random_w1 iter=%0d got %b required %b", i,
                 {if1.carry, if1.sum, if1.out_valid}, {m1, m1v});
      end
      checks++;
      if ({if8.carry, if8.sum, if8.out_valid} !== {m8, m8v}) begin
        failures++;
        $display("FAIL random_w8 iter=%0d got carry=%b sum=%h vld=%b required %b %h %b", i,
                 if8.carry, if8.sum, if8.out_valid, m8[8], m8[7:0], m8v);
      end
      checks++;
      if (if0.out_valid !== m1v) begin
        failures++;
        $display("FAIL random_comb_vld iter=%0d got %b required %b", i, if0.out_valid, m1v);
      end
    end
  endtask

  task automatic test_midreset();
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 8'h34, 1'b0, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    model_clear();
    checks++;
    if ({if1.carry, if1.sum, if1.out_valid, if8.carry, if8.sum, if8.out_valid} !== 13'b0) begin
      failures++;
      $display("FAIL midreset_clear got w1=%b%b%b w8=%b %h %b required zeros",
               if1.carry, if1.sum, if1.out_valid, if8.carry, if8.sum, if8.out_valid);
    end
    #1 rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0);
    checks++;
    if ({if1.carry, if1.sum, if1.out_valid} !== 3'b101) begin
      failures++;
      $display("FAIL midreset_resume got carry,sum,vld=%b required 101",
               {if1.carry, if1.sum, if1.out_valid});
    end
  endtask

  task automatic test_comb();
    logic [1:0] exp;
    if0.A = 1'b1; if0.B = 1'b1; if0.Cin = 1'b1;
    #1;
    checks++;
    if ({if0.carry, if0.sum} !== 2'b11) begin
      failures++;
      $display("FAIL comb_111 got carry,sum=%b required 11", {if0.carry, if0.sum});
    end
    for (int i = 0; i < 6; i++) begin
      if0.A = 1'($urandom); if0.B = 1'($urandom); if0.Cin = 1'($urandom);
      exp = 2'(if0.A) + 2'(if0.B) + 2'(if0.Cin);
      #1;
      checks++;
      if ({if0.carry, if0.sum} !== exp) begin
        failures++;
        $display("FAIL comb_random iter=%0d got %b required %b", i, {if0.carry, if0.sum}, exp);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    @(negedge clk);
    test_exhaustive_w1();
    test_hold();
    test_w8_directed();
    test_random();
    test_midreset();
    test_comb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
